// File: rtl/rangefinder_mul_arbiter.sv
// rangefinder_mul_arbiter: round-robin sharing of one pipelined 32x32 multiplier cell among NUM_REQ requesters
//   clk, reset         : rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready: per-requester request and one-hot grant (transfer on valid & ready)
//   req_src1/req_src2  : packed 32-bit operands, requester i at [32i+31:32i]
//   mul_src1/mul_src2  : operands driven to the multiplier cell (0 when nothing is granted)
//   mul_result         : low 32 product bits returned by the cell MUL_LATENCY cycles later
//   rsp_valid          : one-hot owner of the result currently on rsp_result
//   flush_req/done     : quiesce handshake; busy: operations in flight; issue_count: wrapping transfer count
module rangefinder_mul_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = 1,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [32*NUM_REQ-1:0]  req_src1,
    input  logic [32*NUM_REQ-1:0]  req_src2,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [31:0]            mul_src1,
    output logic [31:0]            mul_src2,
    input  logic [31:0]            mul_result,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [31:0]            rsp_result,
    input  logic                   flush_req,
    output logic                   flush_done,
    output logic                   busy,
    output logic [CNT_W-1:0]       issue_count
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {RUN, DRAIN, FLUSHED} state_t;

    state_t                 state;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       gnt_idx;
    logic [IDX_W-1:0]       cand;
    logic                   gnt;
    logic                   grant_en;
    logic [MUL_LATENCY-1:0] st_v;
    logic [IDX_W-1:0]       st_idx [MUL_LATENCY];

    // reset also masks grants so req_ready reads 0 while reset is held
    assign grant_en = (state == RUN) && !flush_req && !reset;

    // first valid requester after rr_ptr, wrapping around
    always_comb begin
        gnt     = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!gnt && grant_en && req_valid[cand]) begin
                gnt     = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign req_ready  = gnt ? NUM_REQ'(1) << gnt_idx : '0;
    assign mul_src1   = gnt ? req_src1[32*gnt_idx +: 32] : '0;
    assign mul_src2   = gnt ? req_src2[32*gnt_idx +: 32] : '0;
    assign rsp_valid  = st_v[MUL_LATENCY-1] ? NUM_REQ'(1) << st_idx[MUL_LATENCY-1] : '0;
    assign rsp_result = mul_result;
    assign busy       = |st_v;

    // owner tracking runs in lockstep with the cell, which has no stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_v        <= '0;
            for (int i = 0; i < MUL_LATENCY; i++) st_idx[i] <= '0;
            rr_ptr      <= IDX_W'(NUM_REQ-1);
            issue_count <= '0;
        end else begin
            st_v[0]   <= gnt;
            st_idx[0] <= gnt_idx;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                st_v[i]   <= st_v[i-1];
                st_idx[i] <= st_idx[i-1];
            end
            rr_ptr      <= gnt ? gnt_idx : rr_ptr;
            issue_count <= issue_count + CNT_W'(gnt);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            flush_done <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (flush_req) state <= DRAIN;
                end
                DRAIN: begin
                    if (!busy) begin
                        state      <= FLUSHED;
                        flush_done <= 1'b1;
                    end
                end
                FLUSHED: begin
                    if (!flush_req) begin
                        state      <= RUN;
                        flush_done <= 1'b0;
                    end
                end
                default: begin
                    state      <= RUN;
                    flush_done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rangefinder_mul_arbiter.sv
// tb_rangefinder_mul_arbiter: directed checks of the arbiter at latency 1 and at latency 3 with a 4-bit counter
module tb_rangefinder_mul_arbiter;
    logic         clk = 1'b0;
    int           checks = 0;
    int           errors = 0;

    // instance a: NUM_REQ=4, MUL_LATENCY=1, CNT_W=16
    logic         rst_a, flush_a, fd_a, busy_a;
    logic [3:0]   valid_a, ready_a, rv_a;
    logic [127:0] s1_a, s2_a;
    logic [31:0]  ms1_a, ms2_a, mres_a, rr_a;
    logic [15:0]  cnt_a;

    // instance b: NUM_REQ=4, MUL_LATENCY=3, CNT_W=4
    logic         rst_b, flush_b, fd_b, busy_b;
    logic [3:0]   valid_b, ready_b, rv_b;
    logic [127:0] s1_b, s2_b;
    logic [31:0]  ms1_b, ms2_b, mres_b, rr_b;
    logic [3:0]   cnt_b;
    logic [31:0]  pipe_b [3];

    always #5 clk = ~clk;

    rangefinder_mul_arbiter #(.NUM_REQ(4), .MUL_LATENCY(1), .CNT_W(16)) u_dut_a (
        .clk(clk), .reset(rst_a), .req_valid(valid_a), .req_src1(s1_a), .req_src2(s2_a),
        .req_ready(ready_a), .mul_src1(ms1_a), .mul_src2(ms2_a), .mul_result(mres_a),
        .rsp_valid(rv_a), .rsp_result(rr_a), .flush_req(flush_a), .flush_done(fd_a),
        .busy(busy_a), .issue_count(cnt_a));

    rangefinder_mul_arbiter #(.NUM_REQ(4), .MUL_LATENCY(3), .CNT_W(4)) u_dut_b (
        .clk(clk), .reset(rst_b), .req_valid(valid_b), .req_src1(s1_b), .req_src2(s2_b),
        .req_ready(ready_b), .mul_src1(ms1_b), .mul_src2(ms2_b), .mul_result(mres_b),
        .rsp_valid(rv_b), .rsp_result(rr_b), .flush_req(flush_b), .flush_done(fd_b),
        .busy(busy_b), .issue_count(cnt_b));

    // multiplier cells: low 32 bits of the product after 1 and 3 stages
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) mres_a <= '0;
        else       mres_a <= ms1_a * ms2_a;
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            pipe_b[0] <= '0;
            pipe_b[1] <= '0;
            pipe_b[2] <= '0;
        end else begin
            pipe_b[0] <= ms1_b * ms2_b;
            pipe_b[1] <= pipe_b[0];
            pipe_b[2] <= pipe_b[1];
        end
    end
    assign mres_b = pipe_b[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_a = 1'b1; flush_a = 1'b0; valid_a = '0; s1_a = '0; s2_a = '0;
        rst_b = 1'b1; flush_b = 1'b0; valid_b = '0; s1_b = '0; s2_b = '0;
        // reset values
        @(negedge clk); #1;
        chk("rst_ready", 32'(ready_a), 0);
        chk("rst_rsp_valid", 32'(rv_a), 0);
        chk("rst_flush_done", 32'(fd_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_count", 32'(cnt_a), 0);
        chk("rst_mul_src1", ms1_a, 0);
        rst_a = 1'b0; rst_b = 1'b0;
        // single op 3*5
        @(negedge clk); valid_a = 4'b0001; s1_a[31:0] = 32'd3; s2_a[31:0] = 32'd5; #1;
        chk("single_ready", 32'(ready_a), 32'b0001);
        chk("single_mul_src1", ms1_a, 3);
        chk("single_mul_src2", ms2_a, 5);
        chk("single_busy_t", 32'(busy_a), 0);
        @(negedge clk); valid_a = '0; #1;
        chk("single_rsp_valid", 32'(rv_a), 32'b0001);
        chk("single_rsp_result", rr_a, 15);
        chk("single_busy_t1", 32'(busy_a), 1);
        chk("single_count", 32'(cnt_a), 1);
        chk("single_ready_off", 32'(ready_a), 0);
        @(negedge clk); #1;
        chk("single_busy_t2", 32'(busy_a), 0);
        chk("single_rsp_off", 32'(rv_a), 0);
        // low-product wrap on requesters 1 and 3
        @(negedge clk); valid_a = 4'b0010; s1_a[63:32] = 32'hFFFF_FFFF; s2_a[63:32] = 32'hFFFF_FFFF; #1;
        chk("wrap1_ready", 32'(ready_a), 32'b0010);
        @(negedge clk); valid_a = 4'b1000; s1_a[127:96] = 32'h0001_0000; s2_a[127:96] = 32'h0001_0000; #1;
        chk("wrap1_rsp_valid", 32'(rv_a), 32'b0010);
        chk("wrap1_result", rr_a, 32'h0000_0001);
        chk("wrap2_ready", 32'(ready_a), 32'b1000);
        @(negedge clk); valid_a = '0; #1;
        chk("wrap2_rsp_valid", 32'(rv_a), 32'b1000);
        chk("wrap2_result", rr_a, 32'h0000_0000);
        chk("wrap_count", 32'(cnt_a), 3);
        // round robin with all four requesting, src1=i+1, src2=10
        for (int i = 0; i < 4; i++) begin
            s1_a[32*i +: 32] = 32'(i + 1);
            s2_a[32*i +: 32] = 32'd10;
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); valid_a = 4'b1111; #1;
            chk("rr_ready", 32'(ready_a), 32'(1) << (k % 4));
            if (k > 0) begin
                chk("rr_rsp_valid", 32'(rv_a), 32'(1) << ((k - 1) % 4));
                chk("rr_result", rr_a, 32'(10 * ((k - 1) % 4 + 1)));
            end else begin
                chk("rr_rsp_idle", 32'(rv_a), 0);
            end
        end
        @(negedge clk); valid_a = '0; #1;
        chk("rr_last_valid", 32'(rv_a), 32'b1000);
        chk("rr_last_result", rr_a, 40);
        chk("rr_count", 32'(cnt_a), 11);
        // flush with the third request blocked
        @(negedge clk); valid_a = 4'b0001; s1_a[31:0] = 32'd2; s2_a[31:0] = 32'd7; #1;
        chk("fl_ready1", 32'(ready_a), 32'b0001);
        @(negedge clk); valid_a = 4'b0010; s1_a[63:32] = 32'd3; s2_a[63:32] = 32'd4; #1;
        chk("fl_ready2", 32'(ready_a), 32'b0010);
        chk("fl_rsp1", 32'(rv_a), 32'b0001);
        chk("fl_res1", rr_a, 14);
        @(negedge clk); valid_a = 4'b0100; s1_a[95:64] = 32'd6; s2_a[95:64] = 32'd9; flush_a = 1'b1; #1;
        chk("fl_ready3_blocked", 32'(ready_a), 0);
        chk("fl_mul_src1_idle", ms1_a, 0);
        chk("fl_rsp2", 32'(rv_a), 32'b0010);
        chk("fl_res2", rr_a, 12);
        chk("fl_busy3", 32'(busy_a), 1);
        chk("fl_done3", 32'(fd_a), 0);
        @(negedge clk); #1;
        chk("fl_drain_ready", 32'(ready_a), 0);
        chk("fl_drain_busy", 32'(busy_a), 0);
        chk("fl_drain_done", 32'(fd_a), 0);
        chk("fl_drain_rsp", 32'(rv_a), 0);
        @(negedge clk); #1;
        chk("fl_flushed_done", 32'(fd_a), 1);
        chk("fl_flushed_ready", 32'(ready_a), 0);
        @(negedge clk); flush_a = 1'b0; #1;
        chk("fl_release_ready", 32'(ready_a), 0);
        chk("fl_release_done", 32'(fd_a), 1);
        @(negedge clk); #1;
        chk("fl_resume_done", 32'(fd_a), 0);
        chk("fl_resume_ready", 32'(ready_a), 32'b0100);
        @(negedge clk); valid_a = '0; #1;
        chk("fl_resume_rsp", 32'(rv_a), 32'b0100);
        chk("fl_resume_res", rr_a, 54);
        chk("fl_count", 32'(cnt_a), 14);
        // latency 3: two ops in flight, then reset
        @(negedge clk); valid_b = 4'b0010; s1_b[63:32] = 32'd5; s2_b[63:32] = 32'd5; #1;
        chk("b_ready1", 32'(ready_b), 32'b0010);
        @(negedge clk); valid_b = 4'b0001; s1_b[31:0] = 32'd2; s2_b[31:0] = 32'd3; #1;
        chk("b_ready0", 32'(ready_b), 32'b0001);
        @(negedge clk); valid_b = '0; #1;
        chk("b_busy", 32'(busy_b), 1);
        chk("b_count2", 32'(cnt_b), 2);
        chk("b_rsp_early", 32'(rv_b), 0);
        @(negedge clk); #1;
        chk("b_lat3_rsp", 32'(rv_b), 32'b0010);
        chk("b_lat3_res", rr_b, 25);
        rst_b = 1'b1; #1;
        chk("b_rst_rsp", 32'(rv_b), 0);
        chk("b_rst_busy", 32'(busy_b), 0);
        chk("b_rst_count", 32'(cnt_b), 0);
        chk("b_rst_done", 32'(fd_b), 0);
        @(negedge clk); rst_b = 1'b0; valid_b = 4'b0011; s1_b[31:0] = 32'd7; s2_b[31:0] = 32'd8; #1;
        chk("b_post_rst_ready", 32'(ready_b), 32'b0001);
        chk("b_post_rst_rsp", 32'(rv_b), 0);
        @(negedge clk); valid_b = '0; #1;
        chk("b_no_stale1", 32'(rv_b), 0);
        @(negedge clk); #1;
        chk("b_no_stale2", 32'(rv_b), 0);
        @(negedge clk); #1;
        chk("b_new_rsp", 32'(rv_b), 32'b0001);
        chk("b_new_res", rr_b, 56);
        chk("b_count1", 32'(cnt_b), 1);
        // counter wrap: 16 more transfers to requester 0 after the one above
        for (int i = 0; i < 15; i++) begin
            @(negedge clk); valid_b = 4'b0001;
        end
        @(negedge clk); #1;
        chk("b_count16", 32'(cnt_b), 0);
        chk("b_backtoback_ready", 32'(ready_b), 32'b0001);
        @(negedge clk); valid_b = '0; #1;
        chk("b_count17", 32'(cnt_b), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rangefinder_mul_arbiter.md
Name: rangefinder_mul_arbiter

Overview:
Shares one pipelined 32x32 multiplier cell among NUM_REQ requesters. The cell returns the low 32 bits of the product and has no stall input. The arbiter grants one requester per cycle in round-robin order, drives the cell operands and tracks the grant index through the cell latency. It returns each result to its owner with a one-hot valid. A flush handshake quiesces the cell before any software or clock-gating event.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MUL_LATENCY, 1, cycles from operand drive to mul_result valid (1..4)
CNT_W, 16, width of the issue counter

Ports:
clk  in  1  sole clock, all logic rising-edge
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_src1  in  32*NUM_REQ  operand A, requester i at [32i+31:32i]
req_src2  in  32*NUM_REQ  operand B, same packing
req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when valid&ready
mul_src1  out  32  operand A to the multiplier cell
mul_src2  out  32  operand B to the multiplier cell
mul_result  in  32  low 32 bits of the product from the multiplier cell
rsp_valid  out  NUM_REQ  one-hot; result belongs to requester i
rsp_result  out  32  result data, valid when any rsp_valid bit is set
flush_req  in  1  request to quiesce
flush_done  out  1  pipeline empty, no new grants
busy  out  1  at least one operation in flight
issue_count  out  CNT_W  total operations issued, wraps

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: req_ready=0, mul_src1=mul_src2=0, rsp_valid=0, flush_done=0, busy=0, issue_count=0, state=RUN, rr_ptr=NUM_REQ-1, so requester 0 has first priority.
- grant_en = (state==RUN) & ~flush_req. flush_req gates grants combinationally in the same cycle.
- Arbitration is combinational. Search starts at rr_ptr+1 mod NUM_REQ and takes the first requester with req_valid set. req_ready has at most one bit set and is set only when that requester's req_valid is set and grant_en=1.
- Requester rule: req_valid must not depend on req_ready. req_valid and the operands must stay stable until the transfer occurs.
- On a grant, rr_ptr <= granted index at the clock edge. With no grant, rr_ptr holds.
- mul_src1/mul_src2 = the granted requester's operands (combinational mux); 0 when there is no grant.
- Tracking pipeline: MUL_LATENCY stages, each holding {valid, index}. Stage 0 loads {grant, index} every cycle.
- rsp_valid = one-hot decode of the last stage. rsp_result = mul_result passthrough.
- Latency: transfer in cycle t gives the response in cycle t+MUL_LATENCY, unconditionally. There is no response backpressure, so requesters must always accept responses.
- Throughput: one operation per cycle. Back-to-back grants to the same requester are allowed when it is the only one requesting.
- busy = OR of all stage valid bits.
- issue_count increments by 1 per transfer and wraps from 2^CNT_W-1 to 0.
- State machine:
  - RUN: grants allowed. If flush_req=1, go to DRAIN.
  - DRAIN: no grants. When busy=0 at a clock edge, go to FLUSHED.
  - FLUSHED: flush_done=1 (registered, asserted on entry). When flush_req=0, go to RUN; flush_done clears in the same edge.
  - If flush_req deasserts while in DRAIN, the block still completes the drain, then enters FLUSHED, then immediately returns to RUN.
- Reset mid-operation discards in-flight operations: no rsp_valid is produced for them. The multiplier cell is cleared by the same reset at the top level.
- mul_result is don't-care when no rsp_valid bit is set.

Test Plan:
- Single op: req_valid=0001, src1=3, src2=5 at cycle t -> req_ready=0001 at t; rsp_valid=0001, rsp_result=15 at t+1; issue_count=1; busy=1 in cycle t+1 only.
- Wrap of the low product: src1=src2=0xFFFFFFFF -> rsp_result=0x00000001. src1=0x00010000, src2=0x00010000 -> 0x00000000.
- Round-robin: all four requests held continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3. Each response carries the correct owner and product (src1=i+1, src2=10 -> 10,20,30,40).
- Flush: 3 ops issued back-to-back, flush_req raised in the cycle of the 3rd request -> the 3rd is not granted; its last response arrives, then flush_done=1; req_ready stays 0 while flush_req is high; flush_req=0 -> grants resume the next cycle.
- Reset mid-flight with MUL_LATENCY=3: 2 ops in flight, reset pulsed -> rsp_valid, busy, issue_count and flush_done all 0 immediately; after release, requester 0 wins first.
- Counter wrap with CNT_W=4: 17 transfers -> issue_count=1.
